// File: rtl/otp_keystream_gen_pkg.sv
// otp_keystream_gen_pkg: shared FSM state type and LFSR defaults for the keystream generator and its users.
package otp_keystream_gen_pkg;
  localparam int OTP_LFSR_W = 16;
  localparam logic [OTP_LFSR_W-1:0] OTP_TAPS = 16'hB400;
  localparam int OTP_STEPS = 8;
  typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;
endpackage

// File: rtl/otp_keystream_gen_if.sv
// otp_keystream_gen_if: key byte valid/ready handshake to the encryptor.
// Signals: key_byte, key_valid (master drives), key_ready (slave drives).
interface otp_keystream_gen_if;
  logic [7:0] key_byte;
  logic key_valid;
  logic key_ready;
  modport master (output key_byte, key_valid, input key_ready);
  modport slave (input key_byte, key_valid, output key_ready);
endinterface

// File: rtl/otp_lfsr_step.sv
// otp_lfsr_step: combinational single right-shift of a Galois LFSR.
// Ports: d current state in, q next state out.
module otp_lfsr_step #(
  parameter int W = 16,
  parameter logic [W-1:0] TAPS = '0
) (
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  assign q = (d >> 1) ^ (d[0] ? TAPS : '0);
endmodule

// File: rtl/otp_keystream_gen.sv
// otp_keystream_gen: seeded Galois-LFSR keystream source emitting one key byte per STEPS shifts.
// Ports: clk, rst_n (async, active-low), ena (global freeze when low), seed_byte/seed_we/seed_hi
// (byte-wise seed load in IDLE), start/stop, key_if (key_byte/key_valid/key_ready handshake),
// busy (not IDLE), seed_err (sticky zero-seed start), byte_cnt (accepted bytes mod 256).
module otp_keystream_gen
  import otp_keystream_gen_pkg::*;
#(
  parameter int LFSR_W = OTP_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS = OTP_TAPS,
  parameter int STEPS = OTP_STEPS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic [7:0] seed_byte,
  input  logic seed_we,
  input  logic seed_hi,
  input  logic start,
  input  logic stop,
  otp_keystream_gen_if.master key_if,
  output logic busy,
  output logic seed_err,
  output logic [7:0] byte_cnt
);
  state_t state, state_d;
  logic [15:0] seed;
  logic [LFSR_W-1:0] lfsr, lfsr_next;
  logic [2:0] shift_cnt;
  logic [7:0] key_byte;
  logic key_valid;
  logic go, last;
  otp_lfsr_step #(.W(LFSR_W), .TAPS(TAPS)) u_step (.d(lfsr), .q(lfsr_next));
  assign go = start && seed != '0;
  assign last = shift_cnt == 3'(STEPS - 1);
  assign busy = state != IDLE;
  assign key_if.key_byte = key_byte;
  assign key_if.key_valid = key_valid;
  always_comb
    state_d = !ena ? state :
              stop ? IDLE :
              state == IDLE ? (go ? GEN : IDLE) :
              state == GEN ? (last ? HOLD : GEN) :
              (key_if.key_ready ? GEN : HOLD);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // The seed pre-write value feeds go/lfsr, so a same-cycle write and start uses the old seed.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seed <= '0;
      lfsr <= '0;
      shift_cnt <= '0;
      key_byte <= '0;
      key_valid <= 1'b0;
      seed_err <= 1'b0;
      byte_cnt <= '0;
    end else if (ena) begin
      if (state == IDLE && seed_we && seed_hi) seed[15:8] <= seed_byte;
      if (state == IDLE && seed_we && !seed_hi) seed[7:0] <= seed_byte;
      if (stop) key_valid <= 1'b0;
      else if (state == IDLE) begin
        if (start) seed_err <= !go;
        if (go) begin
          lfsr <= LFSR_W'(seed);
          shift_cnt <= '0;
          byte_cnt <= '0;
        end
      end else if (state == GEN) begin
        lfsr <= lfsr_next;
        shift_cnt <= last ? '0 : shift_cnt + 3'd1;
        if (last) begin
          key_byte <= lfsr_next[7:0];
          key_valid <= 1'b1;
        end
      end else if (key_if.key_ready) begin
        key_valid <= 1'b0;
        byte_cnt <= byte_cnt + 8'd1;
        shift_cnt <= '0;
      end
    end
endmodule

// File: doc/otp_keystream_gen.md
OTP_KEYSTREAM_GEN -- requirements
Module: otp_keystream_gen

Interface
REQ-001 SHALL have parameter LFSR_W, default 16, LFSR width in bits.
REQ-002 SHALL have parameter TAPS, default 16'hB400, Galois feedback mask (maximal length, period 65535).
REQ-003 SHALL have parameter STEPS, default 8, LFSR shifts per emitted key byte.
REQ-004 clk  in  1  single clock; all flops rise-edge triggered.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 ena  in  1  global enable; low freezes all state.
REQ-007 seed_byte  in  8  seed data byte.
REQ-008 seed_we  in  1  seed write strobe, one byte per cycle.
REQ-009 seed_hi  in  1  seed byte select: 1 = seed[15:8], 0 = seed[7:0].
REQ-010 start  in  1  begin keystream generation.
REQ-011 stop  in  1  abort generation, return to IDLE.
REQ-012 key_ready  in  1  downstream encryptor accepts key_byte.
REQ-013 key_byte  out  8  keystream byte to encryptor.
REQ-014 key_valid  out  1  key_byte valid.
REQ-015 busy  out  1  high in GEN or HOLD.
REQ-016 seed_err  out  1  sticky: start attempted with zero seed.
REQ-017 byte_cnt  out  8  count of accepted key bytes, mod 256.

Function
REQ-018 SHALL implement FSM states IDLE, GEN, HOLD; busy = (state != IDLE).
REQ-019 With ena low, no register SHALL change (outputs hold); all rules below apply only when ena is high.
REQ-020 In IDLE, seed_we SHALL write seed_byte into the seed half selected by seed_hi; seed_we in GEN/HOLD SHALL be ignored.
REQ-021 In IDLE, start with seed == 0 SHALL set seed_err and remain in IDLE.
REQ-022 In IDLE, start with seed != 0 SHALL load lfsr <= seed, clear shift_cnt and seed_err, clear byte_cnt, enter GEN.
REQ-023 Shift rule: lfsr_next = (lfsr >> 1) XOR (lfsr[0] ? TAPS : 0).
REQ-024 In GEN, each cycle SHALL shift once and increment shift_cnt (3 bits); on the STEPS-th shift, key_byte <= lfsr_next[7:0], key_valid <= 1, enter HOLD.
REQ-025 Latency: key_valid SHALL first rise exactly STEPS (8) edges after the edge that samples start.
REQ-026 In HOLD, key_byte and key_valid SHALL stay stable until key_valid && key_ready; the LFSR SHALL NOT shift in HOLD.
REQ-027 On handshake (HOLD, key_ready high): key_valid <= 0, byte_cnt <= byte_cnt + 1 (255 wraps to 0), shift_cnt <= 0, enter GEN.
REQ-028 stop SHALL take priority over all other events: from GEN or HOLD go to IDLE next edge, key_valid <= 0, no byte_cnt increment even if key_ready is high the same cycle; LFSR state and key_byte hold.
REQ-029 start while in GEN or HOLD SHALL be ignored; start and stop together in IDLE SHALL act as stop (stay IDLE).
REQ-030 seed_we and start in the same IDLE cycle: start SHALL use the seed value before the write.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, seed 0, lfsr 0, shift_cnt 0, key_byte 0, key_valid 0, seed_err 0, byte_cnt 0 (hence busy 0).
REQ-032 Reset mid-GEN or mid-HOLD SHALL drop key_valid immediately, without waiting for a clock edge.

Structure
REQ-033 Shared package SHALL hold the FSM state enum, LFSR_W, TAPS default, and STEPS default, so the encryptor top and the bench use the same values.
REQ-034 One sub-module, otp_lfsr_step (combinational single-step Galois shift), SHALL be instantiated; everything else stays in otp_keystream_gen.

Verification
REQ-035 Seed 0xACE1 (lo 0xE1, hi 0xAC), start, key_ready=1 -> key_valid rises 8 edges after start; key_byte = 0xC4; LFSR = 0xC2C4.
REQ-036 Seed 0x0000, start -> seed_err=1, busy=0, key_valid never rises; a later nonzero-seed start clears seed_err.
REQ-037 key_ready held low 5 cycles in HOLD -> key_byte 0xC4 stable and LFSR unchanged; on the key_ready pulse byte_cnt goes 0 -> 1.
REQ-038 Stop asserted with key_ready in HOLD -> IDLE next edge, key_valid=0, byte_cnt unchanged; seed_we accepted again.
REQ-039 Run 256 handshakes with key_ready=1 -> byte_cnt wraps to 0; ena low for 3 cycles mid-GEN delays key_valid by exactly 3 cycles.
REQ-040 rst_n pulsed low mid-GEN, between clock edges -> all outputs 0 before the next edge; state IDLE.
